// File: rtl/blocpu_pkg.sv
// Shared definitions for the blocpu program loader.
//   state_t      : loader sequencer states
//   err_code_t   : values reported on out_error_code
//   HEADER_BYTES : length header size at the start of a program stream
package blocpu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_INST_HI,
    ST_INST_LO,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_CORE_RESET,
    ST_CORE_START,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_HIGH = 2'd1,
    ERR_LENGTH   = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_t;

  localparam int unsigned HEADER_BYTES = 2;

endpackage

// File: rtl/blocpu_run_watchdog.sv
// Run watchdog: loadable down-counter with enable, clear and expiry pulse.
//   clock, in_reset : clock, asynchronous active-high reset
//   clear           : force the count to zero
//   load            : preload TIMEOUT_CYCLES
//   enable          : count down one per cycle while nonzero
//   expired         : high in the enabled cycle whose edge reaches zero
// TIMEOUT_CYCLES = 0 disables the watchdog (expired never asserts).
module blocpu_run_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic clock,
  input  logic in_reset,
  input  logic clear,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] count_q;

  always_ff @(posedge clock or posedge in_reset) begin
    if (in_reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CW'(TIMEOUT_CYCLES);
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count_q == CW'(1));

endmodule

// File: rtl/blocpu_loader.sv
// Program loader and run sequencer for the blocpu core.
// Receives a length-prefixed program over a byte valid/ready link, writes each
// instruction into the core's instruction memory, pulses the core reset,
// starts the core and waits for it to halt (or for the watchdog to expire).
//   in_start                      : begin a load (honoured in IDLE/DONE/ERROR)
//   in_byte / in_byte_valid       : stream byte and its valid
//   out_byte_ready                : byte accepted this cycle when valid
//   out_instruction(_address)     : write data / address to the core
//   out_instruction_write         : write strobe to the core
//   out_core_reset / _running     : core reset and run controls
//   in_core_running               : core status
//   out_busy / out_done / out_error / out_error_code : loader status
module blocpu_loader
  import blocpu_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = 12,
  parameter int unsigned ADDRESS_WIDTH     = 16,
  parameter int unsigned RESET_CYCLES      = 2,
  parameter int unsigned TIMEOUT_CYCLES    = 0
) (
  input  logic                         clock,
  input  logic                         in_reset,
  input  logic                         in_start,
  input  logic [7:0]                   in_byte,
  input  logic                         in_byte_valid,
  output logic                         out_byte_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [ADDRESS_WIDTH-1:0]     out_instruction_address,
  output logic                         out_instruction_write,
  output logic                         out_core_reset,
  output logic                         out_core_running,
  input  logic                         in_core_running,
  output logic                         out_busy,
  output logic                         out_done,
  output logic                         out_error,
  output logic [1:0]                   out_error_code
);

  localparam int unsigned LEN_W = ADDRESS_WIDTH + 1;
  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  // High-byte bits above instr[INSTRUCTION_WIDTH-1:8] must be zero.
  localparam logic [7:0] HI_MASK = 8'hFF << (INSTRUCTION_WIDTH - 8);

  state_t                       state_q, state_d;
  err_code_t                    err_d, code_q;
  logic                         accept;
  logic [15:0]                  len_word;
  logic                         len_overflow;
  logic [7:0]                   len_hi_q;
  logic [7:0]                   inst_hi_q;
  logic [LEN_W-1:0]             rem_q;
  logic [ADDRESS_WIDTH-1:0]     addr_q;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;
  logic [RST_W-1:0]             rst_cnt_q;
  logic                         seen_high_q;
  logic                         done_q, error_q;
  logic                         enter_len_hi, enter_done, enter_error, enter_core_reset;
  logic                         wd_clear, wd_load, wd_enable, wd_expired;

  assign out_byte_ready = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_INST_HI, ST_INST_LO};
  assign accept         = in_byte_valid && out_byte_ready;
  assign len_word       = {len_hi_q, in_byte};
  assign len_overflow   = {17'b0, len_word} > (33'd1 << ADDRESS_WIDTH);

  always_comb begin
    state_d               = state_q;
    err_d                 = ERR_NONE;
    out_instruction_write = 1'b0;
    out_core_reset        = 1'b0;
    out_core_running      = 1'b0;
    out_busy              = 1'b1;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        out_busy = 1'b0;
        if (in_start) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (len_overflow) begin
            state_d = ST_ERROR;
            err_d   = ERR_LENGTH;
          end else if (len_word == 16'd0) begin
            state_d = ST_CORE_RESET;
          end else begin
            state_d = ST_INST_HI;
          end
        end
      end
      ST_INST_HI: begin
        if (accept) begin
          if (|(in_byte & HI_MASK)) begin
            state_d = ST_ERROR;
            err_d   = ERR_BAD_HIGH;
          end else begin
            state_d = ST_INST_LO;
          end
        end
      end
      ST_INST_LO:  if (accept) state_d = ST_WR_SETUP;
      ST_WR_SETUP: state_d = ST_WR_STROBE;
      ST_WR_STROBE: begin
        out_instruction_write = 1'b1;
        state_d = (rem_q == LEN_W'(1)) ? ST_CORE_RESET : ST_INST_HI;
      end
      ST_CORE_RESET: begin
        out_core_reset = 1'b1;
        if (rst_cnt_q == '0) state_d = ST_CORE_START;
      end
      ST_CORE_START: begin
        out_core_running = 1'b1;
        if (wd_expired) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        out_core_running = 1'b1;
        if (seen_high_q && !in_core_running) begin
          state_d = ST_DONE;
        end else if (wd_expired) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_len_hi     = (state_d == ST_LEN_HI)     && (state_q != ST_LEN_HI);
  assign enter_done       = (state_d == ST_DONE)       && (state_q != ST_DONE);
  assign enter_error      = (state_d == ST_ERROR)      && (state_q != ST_ERROR);
  assign enter_core_reset = (state_d == ST_CORE_RESET) && (state_q != ST_CORE_RESET);

  always_ff @(posedge clock or posedge in_reset) begin
    if (in_reset) begin
      state_q     <= ST_IDLE;
      len_hi_q    <= '0;
      inst_hi_q   <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      instr_q     <= '0;
      rst_cnt_q   <= '0;
      seen_high_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      state_q <= state_d;

      if ((state_q == ST_LEN_HI) && accept) len_hi_q <= in_byte;

      // Remaining-instruction count; one wider than the address so that a
      // full 2^ADDRESS_WIDTH program is representable.
      if ((state_q == ST_LEN_LO) && accept) begin
        rem_q <= LEN_W'(len_word);
      end else if (state_q == ST_WR_STROBE) begin
        rem_q <= rem_q - LEN_W'(1);
      end

      if (enter_len_hi) begin
        addr_q <= '0;
      end else if (state_q == ST_WR_STROBE) begin
        addr_q <= addr_q + ADDRESS_WIDTH'(1);
      end

      if ((state_q == ST_INST_HI) && accept) inst_hi_q <= in_byte;
      if ((state_q == ST_INST_LO) && accept) instr_q <= INSTRUCTION_WIDTH'({inst_hi_q, in_byte});

      if (enter_core_reset) begin
        rst_cnt_q <= RST_W'(RESET_CYCLES - 1);
      end else if ((state_q == ST_CORE_RESET) && (rst_cnt_q != '0)) begin
        rst_cnt_q <= rst_cnt_q - RST_W'(1);
      end

      // Halt is a fall of the core status after it was seen high while running.
      if (state_q == ST_RUN) begin
        seen_high_q <= seen_high_q | in_core_running;
      end else begin
        seen_high_q <= 1'b0;
      end

      if (enter_len_hi) begin
        done_q  <= 1'b0;
        error_q <= 1'b0;
        code_q  <= ERR_NONE;
      end else begin
        if (enter_done) done_q <= 1'b1;
        if (enter_error) begin
          error_q <= 1'b1;
          code_q  <= err_d;
        end
      end
    end
  end

  // Watchdog preloads during the core reset pulse and counts from CORE_START.
  assign wd_clear  = !out_busy;
  assign wd_load   = (state_q == ST_CORE_RESET);
  assign wd_enable = (state_q == ST_CORE_START) || (state_q == ST_RUN);

  blocpu_run_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .in_reset(in_reset),
    .clear   (wd_clear),
    .load    (wd_load),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  assign out_instruction         = instr_q;
  assign out_instruction_address = addr_q;
  assign out_done                = done_q;
  assign out_error               = error_q;
  assign out_error_code          = code_q;

endmodule

// File: doc/blocpu_loader.md
# blocpu_loader

Program loader and run sequencer for the blocpu core. It receives a program as a byte stream over a valid/ready handshake and writes each 12-bit instruction into the core's instruction memory through the core's write port. It then pulses the core's reset, starts the core, and monitors it until it halts or a watchdog expires. It sits between the host-facing byte link and the core's `in_instruction*` / `in_reset` / `in_running` inputs.

## Interface
- `INSTRUCTION_WIDTH`, 12: instruction word width; must be ≤ 16.
- `ADDRESS_WIDTH`, 16: instruction address width.
- `RESET_CYCLES`, 2: length of the core reset pulse; must be ≥ 1.
- `TIMEOUT_CYCLES`, 0: run watchdog limit; 0 disables the watchdog.
- `clock` in 1: system clock; all logic is on the rising edge.
- `in_reset` in 1: reset, asynchronous, active-high.
- `in_start` in 1: begin a load; sampled only in IDLE, DONE and ERROR.
- `in_byte` in 8: stream byte.
- `in_byte_valid` in 1: `in_byte` is valid.
- `out_byte_ready` out 1: loader accepts a byte this cycle.
- `out_instruction` out INSTRUCTION_WIDTH: instruction to the core.
- `out_instruction_address` out ADDRESS_WIDTH: write address to the core.
- `out_instruction_write` out 1: write strobe to the core (the core captures on its rising edge).
- `out_core_reset` out 1: drives the core's `in_reset`.
- `out_core_running` out 1: drives the core's `in_running`.
- `in_core_running` in 1: the core's `out_running` status.
- `out_busy` out 1: state is not IDLE, DONE or ERROR.
- `out_done` out 1: the core halted normally; held until the next start.
- `out_error` out 1: the load or run failed; held until the next start.
- `out_error_code` out 2: 0 none, 1 bad instruction high byte, 2 length overflow, 3 timeout.

## Operation
- **Stream format.** Length N (big-endian, 2 bytes) is followed by N instructions of 2 bytes each, high byte first.
  - The high byte holds `instr[INSTRUCTION_WIDTH-1:8]` in its low bits; its upper bits must be 0.
- **Byte acceptance.** A byte is accepted at a rising edge where `in_byte_valid && out_byte_ready`.
- **Byte-accepting states.** `out_byte_ready` is 1 only in LEN_HI, LEN_LO, INST_HI and INST_LO.
- **States and transitions.**
  - IDLE / DONE / ERROR: on `in_start`, go to LEN_HI. Entering LEN_HI clears `out_done`, `out_error`, `out_error_code` and the address counter.
  - LEN_HI → LEN_LO on accept.
  - LEN_LO on accept:
    - If N > 2^ADDRESS_WIDTH, go to ERROR with code 2.
    - If N == 0, go to CORE_RESET.
    - Otherwise, go to INST_HI.
  - INST_HI on accept: if any of the high byte's upper bits are 1, go to ERROR with code 1; otherwise latch the byte and go to INST_LO.
  - INST_LO → WR_SETUP on accept. `out_instruction` and `out_instruction_address` are driven here and stay stable.
  - WR_SETUP → WR_STROBE. `out_instruction_write` is 1 only during WR_STROBE.
  - WR_STROBE: increment the address. If N instructions have now been written, go to CORE_RESET; otherwise go to INST_HI.
  - CORE_RESET: `out_core_reset` = 1 for RESET_CYCLES cycles, then go to CORE_START.
  - CORE_START: `out_core_running` = 1, then go to RUN.
  - RUN: `out_core_running` stays 1.
    - Go to DONE when `in_core_running` falls from a sampled 1 to 0.
    - If TIMEOUT_CYCLES ≠ 0 and the RUN cycle count reaches TIMEOUT_CYCLES, go to ERROR with code 3.
    - `in_start` is ignored while busy.
  - Entering DONE or ERROR drives `out_core_running` to 0.
- **Widths.** The length counter is ADDRESS_WIDTH+1 bits. The address counter is ADDRESS_WIDTH bits; writing N = 2^ADDRESS_WIDTH instructions wraps it to 0, which is legal.
- **Mid-load failure.** The core is not started after ERROR; instructions already written remain in the core's instruction memory.

## Timing
- **Reset.** `in_reset` returns the loader to IDLE immediately. All outputs reset to 0 and all counters are cleared.
- **Reset mid-write.** An active `out_instruction_write` drops asynchronously with reset.
- **Start to ready.** `out_byte_ready` rises 1 cycle after `in_start` is sampled.
- **Per-instruction throughput.** The minimum is 4 cycles per instruction (2 accepts, WR_SETUP, WR_STROBE). `out_byte_ready` is 0 during the 2 write cycles.
- **Write latency.** The strobe rises 2 cycles after the low byte is accepted. Address and data are stable 1 cycle before the strobe and through it.
- **Core start.** `out_core_running` rises RESET_CYCLES+1 cycles after the last strobe, or after LEN_LO when N = 0. `out_core_reset` is already 0 at that point.
- **Halt detection.** `out_done` rises 1 cycle after `in_core_running` is sampled low following a sampled high.
- **Timeout.** The timeout is measured from CORE_START.

## Structure
- Shared package `blocpu_pkg`:
  - state encoding;
  - error-code constants;
  - stream header width (2 bytes).
- Sub-module `blocpu_run_watchdog`: a loadable down-counter with enable, clear, and expiry pulse, parameterised by TIMEOUT_CYCLES.

## Test plan
- **Normal load.** Stream `00 02 08 A5 01 3C`. Require:
  - writes of 0x8A5 @0 and 0x13C @1;
  - exactly 2 strobe pulses;
  - a core reset pulse 2 cycles long, then running.
  - Model the core halting after 10 cycles; `out_done` = 1.
- **Bad high byte.** Stream `00 01 18 00`. Require ERROR with code 1, no strobe, and `out_core_running` never set.
- **Zero length.** Stream `00 00`. Require core reset and start with no writes; `out_done` follows the core halt.
- **Timeout.** With TIMEOUT_CYCLES = 50 and the core never halting, require ERROR with code 3 at exactly 50 cycles after CORE_START and `out_core_running` = 0.
- **Backpressure and reset.** Toggle `in_byte_valid` randomly; require no byte to be lost or duplicated. Assert `in_reset` during WR_STROBE; require all outputs 0 and IDLE immediately.
- **Restart.** Issue `in_start` from DONE; require the flags to clear and a new load to begin at address 0.
